// File: rtl/irq_pkg.sv
// Shared constants and state encoding for the interrupt request stage.
// The encoder sitting beside this block must use the same widths.
package irq_pkg;

    localparam int IRQ_N    = 8;
    localparam int IRQ_IDW  = 3;
    localparam int IRQ_OVFW = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } irq_state_e;

endpackage : irq_pkg

// File: rtl/irq_sync_edge.sv
// One request line: two-flop synchroniser followed by a rising-edge detector.
// The edge output is a single-cycle pulse in the clk domain.
module irq_sync_edge
    import irq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_in,
    output logic req_edge
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = req_in;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign req_edge = s2_q & ~prev_q;

endmodule : irq_sync_edge

// File: rtl/irq_request_stage.sv
// Latches synchronised request edges as sticky pending bits, presents them masked to an
// external priority encoder, and issues the encoder's pick through a valid/ack handshake.
module irq_request_stage
    import irq_pkg::*;
#(
    parameter int N    = IRQ_N,
    parameter int IDW  = IRQ_IDW,
    parameter int OVFW = IRQ_OVFW
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            mask_we,
    input  logic [N-1:0]    mask_wdata,
    output logic [N-1:0]    pend_vec,
    input  logic [IDW-1:0]  enc_id,
    output logic            irq_valid,
    output logic [IDW-1:0]  irq_id,
    input  logic            irq_ack,
    output logic [N-1:0]    pending,
    output logic [OVFW-1:0] ovf_cnt
);

    logic [N-1:0]    req_edge;
    logic [N-1:0]    clr_vec;
    logic            overrun_hit;

    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    mask_q, mask_d;
    logic [OVFW-1:0] ovf_q, ovf_d;
    logic [IDW-1:0]  irq_id_q, irq_id_d;
    irq_state_e      state_q, state_d;

    for (genvar i = 0; i < N; i++) begin : g_sync
        irq_sync_edge u_sync_edge (
            .clk      (clk),
            .rst      (rst),
            .req_in   (req[i]),
            .req_edge (req_edge[i])
        );
    end

    // Only an accepted handshake clears a bit; a fresh edge on the same bit overrides it.
    always_comb begin
        clr_vec = '0;
        if (state_q == ST_ISSUE && irq_ack) begin
            clr_vec[irq_id_q] = 1'b1;
        end
        pending_d   = (pending_q & ~clr_vec) | req_edge;
        overrun_hit = |(req_edge & pending_q & ~clr_vec);
    end

    always_comb begin
        ovf_d = ovf_q;
        if (overrun_hit && ovf_q != {OVFW{1'b1}}) begin
            ovf_d = ovf_q + OVFW'(1);
        end
        mask_d = mask_q;
        if (mask_we) begin
            mask_d = mask_wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                if (|pend_vec) begin
                    irq_id_d = enc_id;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (irq_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= '1;
            ovf_q     <= '0;
            irq_id_q  <= '0;
            state_q   <= ST_IDLE;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ovf_q     <= ovf_d;
            irq_id_q  <= irq_id_d;
            state_q   <= state_d;
        end
    end

    assign pend_vec  = pending_q & mask_q;
    assign pending   = pending_q;
    assign ovf_cnt   = ovf_q;
    assign irq_id    = irq_id_q;
    assign irq_valid = (state_q == ST_ISSUE);

endmodule : irq_request_stage

// File: tb/tb_irq_request_stage.sv
// Directed bench for irq_request_stage with a behavioural 8-to-3 priority encoder
// closing the pend_vec -> enc_id loop.
module tb_irq_request_stage;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] pend_vec;
    logic [2:0] enc_id;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic [7:0] pending;
    logic [7:0] ovf_cnt;

    int checks   = 0;
    int failures = 0;

    irq_request_stage dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .pend_vec   (pend_vec),
        .enc_id     (enc_id),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .pending    (pending),
        .ovf_cnt    (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external encoder: index of the highest set bit.
    always_comb begin
        enc_id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend_vec[i]) enc_id = 3'(i);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] req_v, input logic ack_v);
        req     = req_v;
        irq_ack = ack_v;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic writeMask(input logic [7:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        step(1);
        mask_we    = 1'b0;
    endtask

    task automatic waitValid(input string tag, input int budget);
        int n;
        n = 0;
        while (irq_valid !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        checkOutput(tag, 32'(irq_valid), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req        = 8'h00;
        irq_ack    = 1'b0;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        step(2);
        rst = 1'b0;
        step(1);
        checkOutput("rst_valid",   32'(irq_valid), 32'd0);
        checkOutput("rst_pending", 32'(pending),   32'h00);
        checkOutput("rst_ovf",     32'(ovf_cnt),   32'h00);
        checkOutput("rst_id",      32'(irq_id),    32'd0);

        // Test 1: reset mid-run with a masked pending line, mask must come back as all-ones
        writeMask(8'h00);
        applyStimulus(8'h10, 1'b0);
        step(4);
        checkOutput("t1_pending", 32'(pending),   32'h10);
        checkOutput("t1_pendvec", 32'(pend_vec),  32'h00);
        checkOutput("t1_valid",   32'(irq_valid), 32'd0);
        #2;
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0);
        #1;
        checkOutput("t1_rst_pending", 32'(pending),  32'h00);
        checkOutput("t1_rst_ovf",     32'(ovf_cnt),  32'h00);
        checkOutput("t1_rst_pendvec", 32'(pend_vec), 32'h00);
        step(1);
        rst = 1'b0;
        step(1);

        // Test 2: single request, exact latency k+2 pending, k+3 valid
        applyStimulus(8'h08, 1'b0);
        step(1);
        checkOutput("t2_k_pending",  32'(pending), 32'h00);
        step(1);
        checkOutput("t2_k1_pending", 32'(pending), 32'h00);
        step(1);
        checkOutput("t2_k2_pending", 32'(pending),   32'h08);
        checkOutput("t2_k2_pendvec", 32'(pend_vec),  32'h08);
        checkOutput("t2_k2_valid",   32'(irq_valid), 32'd0);
        step(1);
        checkOutput("t2_k3_valid", 32'(irq_valid), 32'd1);
        checkOutput("t2_k3_id",    32'(irq_id),    32'd3);
        applyStimulus(8'h00, 1'b1);
        step(1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t2_ack_valid",   32'(irq_valid), 32'd0);
        checkOutput("t2_ack_pending", 32'(pending),   32'h00);
        step(3);
        checkOutput("t2_idle_valid", 32'(irq_valid), 32'd0);

        // Test 3: simultaneous requests, highest index first
        applyStimulus(8'h81, 1'b0);
        step(3);
        checkOutput("t3_pending", 32'(pending), 32'h81);
        step(1);
        checkOutput("t3_valid1", 32'(irq_valid), 32'd1);
        checkOutput("t3_id1",    32'(irq_id),    32'd7);
        applyStimulus(8'h00, 1'b1);
        step(1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t3_ack1_pending", 32'(pending),   32'h01);
        checkOutput("t3_ack1_valid",   32'(irq_valid), 32'd0);
        waitValid("t3_valid2", 4);
        checkOutput("t3_id2", 32'(irq_id), 32'd0);
        applyStimulus(8'h00, 1'b1);
        step(1);
        applyStimulus(8'h00, 1'b0);
        step(3);
        checkOutput("t3_end_pending", 32'(pending),   32'h00);
        checkOutput("t3_end_valid",   32'(irq_valid), 32'd0);

        // Test 4: masked line latches but is not presented until unmasked
        writeMask(8'hDF);
        applyStimulus(8'h20, 1'b0);
        step(1);
        applyStimulus(8'h00, 1'b0);
        step(3);
        checkOutput("t4_pending", 32'(pending),   32'h20);
        checkOutput("t4_pendvec", 32'(pend_vec),  32'h00);
        checkOutput("t4_valid",   32'(irq_valid), 32'd0);
        writeMask(8'hFF);
        checkOutput("t4_unmask_pendvec", 32'(pend_vec), 32'h20);
        step(1);
        checkOutput("t4_unmask_valid", 32'(irq_valid), 32'd1);
        checkOutput("t4_unmask_id",    32'(irq_id),    32'd5);
        applyStimulus(8'h00, 1'b1);
        step(1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("t4_ack_pending", 32'(pending), 32'h00);
        step(2);

        // Test 5a: second edge on an outstanding line counts one overrun
        applyStimulus(8'h04, 1'b0);
        step(4);
        checkOutput("t5_valid", 32'(irq_valid), 32'd1);
        checkOutput("t5_id",    32'(irq_id),    32'd2);
        applyStimulus(8'h00, 1'b0);
        step(3);
        applyStimulus(8'h04, 1'b0);
        step(3);
        checkOutput("t5_ovf",       32'(ovf_cnt),   32'h01);
        checkOutput("t5_ovf_valid", 32'(irq_valid), 32'd1);
        applyStimulus(8'h00, 1'b0);
        step(3);

        // Test 5b: new edge lands on the ack cycle, set wins and the line is re-issued
        applyStimulus(8'h04, 1'b0);
        step(2);
        applyStimulus(8'h04, 1'b1);
        step(1);
        applyStimulus(8'h04, 1'b0);
        checkOutput("t5b_valid",   32'(irq_valid), 32'd0);
        checkOutput("t5b_pending", 32'(pending),   32'h04);
        checkOutput("t5b_ovf",     32'(ovf_cnt),   32'h01);
        waitValid("t5b_reissue_valid", 4);
        checkOutput("t5b_reissue_id", 32'(irq_id), 32'd2);
        applyStimulus(8'h00, 1'b0);
        step(2);

        // Test 6: reset while an issue is outstanding, no ack
        checkOutput("t6_pre_valid", 32'(irq_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_valid",   32'(irq_valid), 32'd0);
        checkOutput("t6_rst_pending", 32'(pending),   32'h00);
        checkOutput("t6_rst_ovf",     32'(ovf_cnt),   32'h00);
        step(1);
        rst = 1'b0;
        step(5);
        checkOutput("t6_post_valid",   32'(irq_valid), 32'd0);
        checkOutput("t6_post_pending", 32'(pending),   32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_irq_request_stage
